wtch_time_tx: RTL and testbench
===============================

# wtch_time_tx

Time-report serializer for the UART dual watch: on request it snapshots the watch time (hour, min, sec, centisecond) and emits it as an ASCII frame `HH:MM:SS.CC` plus optional CR LF. Output is one byte at a time over a valid/ready handshake into the UART transmitter. It sits between the watch datapath outputs and the UART TX byte interface. It is the outbound counterpart of the command path that drives the watch controls.

## Interface
- `SEND_CRLF`, default 1: 1 appends 0x0D 0x0A (13-byte frame); 0 sends an 11-byte frame.
- `clk` in 1: system clock (100 MHz).
- `rst` in 1: asynchronous, active-low reset.
- `req` in 1: report request. Each high cycle counts as one request.
- `hour` in 5: hours, 0–23.
- `min` in 6: minutes, 0–59.
- `sec` in 6: seconds, 0–59.
- `msec` in 7: centiseconds, 0–99.
- `tx_ready` in 1: UART TX can accept a byte.
- `tx_valid` out 1: `tx_data` holds a frame byte.
- `tx_data` out 8: ASCII byte.
- `busy` out 1: frame in progress (snapshot taken, last byte not yet accepted).
- `done` out 1: one-cycle pulse after the last byte is accepted.

## Operation
- State machine has two states, IDLE and SEND, plus a 4-bit byte index `idx` and a `pending` flag.
- **Reset** (asynchronous, while `rst` = 0):
  - State goes to IDLE; `idx` = 0; `pending` = 0.
  - `tx_valid` = 0, `tx_data` = 0x00, `busy` = 0, `done` = 0.
  - Reset mid-frame aborts the frame with no further bytes.
- **IDLE → SEND**: taken when `req` = 1 or `pending` = 1.
  - On that edge all four time inputs are registered into a snapshot.
  - `idx` is set to 0 and `pending` is cleared.
- **Frame content**: the frame is built only from the snapshot, so input changes during a frame have no effect.
- **Byte order** for idx 0..12: H tens, H ones, ':'(0x3A), M tens, M ones, ':', S tens, S ones, '.'(0x2E), C tens, C ones, CR(0x0D), LF(0x0A).
- **Digit encoding**: digit = 0x30 + value; tens = v/10, ones = v%10.
  - A snapshot value above its legal maximum saturates before conversion: hour→23, min/sec→59, msec→99.
- **SEND state**:
  - `tx_valid` = 1 and `tx_data` = byte[idx].
  - A byte transfers on a rising edge with `tx_valid` && `tx_ready`; `idx` then increments.
  - On the transfer of the last byte (idx 12, or idx 10 when `SEND_CRLF` = 0) the block returns to IDLE and pulses `done` for one cycle.
- **Backpressure**: while `tx_valid` && !`tx_ready`, `tx_data` and `idx` hold stable. `tx_valid` never drops before the transfer.
- **Request while busy**:
  - `req` in SEND, or on the same cycle as the last transfer, sets `pending`.
  - Multiple such requests collapse into one.
  - The next frame starts from IDLE on the following cycle, with a fresh snapshot taken at that entry.
- **Flags**: `busy` = 1 exactly while in SEND. `done` and `busy` are never both high.

## Timing
- `req` high at edge N (in IDLE) → snapshot at edge N, `tx_valid` = 1 with byte 0 from cycle N+1.
- Byte throughput is 1 per cycle when `tx_ready` is held high. A 13-byte frame occupies SEND for 13 cycles; `done` is high on the cycle after the last transfer.
- With `pending` set, IDLE lasts exactly 1 cycle (the `done` cycle) before `tx_valid` rises again.
- All outputs are registered; there is no combinational path from `tx_ready` or `req` to any output.

## Test plan
- **Basic frame**: hour=12, min=34, sec=56, msec=78, `tx_ready`=1, 1-cycle `req` → `tx_data` sequence 31 32 3A 33 34 3A 35 36 2E 37 38 0D 0A on 13 consecutive cycles; `done` 1 cycle after the last byte; `busy` low afterwards.
- **Backpressure**: `tx_ready` toggled pseudo-randomly; time inputs changed every cycle after `req` → same 13 bytes as the snapshot, with `tx_data` stable during every stall.
- **Zero and max values**:
  - All inputs 0 → "00:00:00.00\r\n".
  - hour=23, min=59, sec=59, msec=99 → "23:59:59.99\r\n".
  - hour=31, msec=127 → hour digits "23", centisecond digits "99".
- **Request while busy**: `req` at byte 4 and again at byte 9 → exactly one extra frame. It starts 1 cycle after `done`, with values sampled at that start.
- **Reset mid-frame**: `rst` low at byte 6 → `tx_valid`, `busy` and `done` immediately 0. After release, the next `req` produces a complete frame from byte 0.
- **`SEND_CRLF`=0**: same stimulus as the basic frame → 11 bytes ending 0x38, with `done` after the 11th byte.

Source files
------------

// File: rtl/wtch_time_tx.sv
// Time-report serializer: snapshots hour/min/sec/centisecond on request and streams
// the ASCII frame "HH:MM:SS.CC" (plus optional CR LF) one byte per valid/ready transfer.
module wtch_time_tx #(
   parameter bit SEND_CRLF = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_req,
   input  logic [4:0] i_hour,
   input  logic [5:0] i_min,
   input  logic [5:0] i_sec,
   input  logic [6:0] i_msec,
   input  logic       i_tx_ready,
   output logic       o_tx_valid,
   output logic [7:0] o_tx_data,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_dbg_state
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   localparam logic [3:0] LAST_IDX = SEND_CRLF ? 4'd12 : 4'd10;

   // Handshake: a byte moves on a rising edge where o_tx_valid && i_tx_ready; while
   // o_tx_valid is high and i_tx_ready is low, o_tx_data holds and o_tx_valid stays high.

   state_t     r_state;
   logic [3:0] r_idx;
   logic       r_pending;
   logic [4:0] r_hour;
   logic [5:0] r_min;
   logic [5:0] r_sec;
   logic [6:0] r_msec;
   logic       r_tx_valid;
   logic [7:0] r_tx_data;
   logic       r_busy;
   logic       r_done;

   logic [4:0] w_hour_sat;
   logic [5:0] w_min_sat;
   logic [5:0] w_sec_sat;
   logic [6:0] w_msec_sat;
   logic [7:0] w_first_byte;
   logic [7:0] w_next_byte;
   logic       w_xfer;
   logic       w_last;

   function automatic logic [7:0] tens_char(input logic [6:0] v);
      logic [6:0] q;
      q = v / 7'd10;
      return 8'h30 + {1'b0, q};
   endfunction

   function automatic logic [7:0] ones_char(input logic [6:0] v);
      logic [6:0] r;
      r = v % 7'd10;
      return 8'h30 + {1'b0, r};
   endfunction

   function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [6:0] h,
                                             input logic [6:0] m, input logic [6:0] s,
                                             input logic [6:0] c);
      case (idx)
         4'd0:    return tens_char(h);
         4'd1:    return ones_char(h);
         4'd2:    return 8'h3A;
         4'd3:    return tens_char(m);
         4'd4:    return ones_char(m);
         4'd5:    return 8'h3A;
         4'd6:    return tens_char(s);
         4'd7:    return ones_char(s);
         4'd8:    return 8'h2E;
         4'd9:    return tens_char(c);
         4'd10:   return ones_char(c);
         4'd11:   return 8'h0D;
         4'd12:   return 8'h0A;
         default: return 8'h00;
      endcase
   endfunction

   // Saturation is applied at capture so the snapshot always holds legal values.
   assign w_hour_sat = (i_hour > 5'd23) ? 5'd23 : i_hour;
   assign w_min_sat  = (i_min  > 6'd59) ? 6'd59 : i_min;
   assign w_sec_sat  = (i_sec  > 6'd59) ? 6'd59 : i_sec;
   assign w_msec_sat = (i_msec > 7'd99) ? 7'd99 : i_msec;

   assign w_first_byte = frame_byte(4'd0, {2'b00, w_hour_sat}, {1'b0, w_min_sat},
                                    {1'b0, w_sec_sat}, w_msec_sat);
   assign w_next_byte  = frame_byte(r_idx + 4'd1, {2'b00, r_hour}, {1'b0, r_min},
                                    {1'b0, r_sec}, r_msec);
   assign w_xfer = r_tx_valid & i_tx_ready;
   assign w_last = (r_idx == LAST_IDX);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state    <= S_IDLE;
         r_idx      <= 4'd0;
         r_pending  <= 1'b0;
         r_hour     <= 5'd0;
         r_min      <= 6'd0;
         r_sec      <= 6'd0;
         r_msec     <= 7'd0;
         r_tx_valid <= 1'b0;
         r_tx_data  <= 8'h00;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_req || r_pending) begin
                  r_state    <= S_SEND;
                  r_idx      <= 4'd0;
                  r_pending  <= 1'b0;
                  r_hour     <= w_hour_sat;
                  r_min      <= w_min_sat;
                  r_sec      <= w_sec_sat;
                  r_msec     <= w_msec_sat;
                  r_tx_valid <= 1'b1;
                  r_tx_data  <= w_first_byte;
                  r_busy     <= 1'b1;
               end
            end
            S_SEND: begin
               // Requests during a frame, including on the last transfer, collapse to one.
               if (i_req) r_pending <= 1'b1;
               if (w_xfer) begin
                  if (w_last) begin
                     r_state    <= S_IDLE;
                     r_idx      <= 4'd0;
                     r_tx_valid <= 1'b0;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                  end else begin
                     r_idx     <= r_idx + 4'd1;
                     r_tx_data <= w_next_byte;
                  end
               end
            end
         endcase
      end
   end

   assign o_tx_valid  = r_tx_valid;
   assign o_tx_data   = r_tx_data;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wtch_time_tx.sv
// Directed bench for wtch_time_tx: frame content, backpressure, saturation,
// request-while-busy, mid-frame reset, and the CR/LF-less variant.
module tb_wtch_time_tx;

   logic       clk;
   logic       rst;
   logic       req;
   logic       req_nc;
   logic [4:0] hour;
   logic [5:0] min;
   logic [5:0] sec;
   logic [6:0] msec;
   logic       tx_ready;

   logic       tx_valid, busy, done, dbg_state;
   logic [7:0] tx_data;
   logic       nc_valid, nc_busy, nc_done, nc_dbg_state;
   logic [7:0] nc_data;

   int checks = 0;
   int errors = 0;

   wtch_time_tx #(.SEND_CRLF(1'b1)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_hour(hour), .i_min(min), .i_sec(sec),
      .i_msec(msec), .i_tx_ready(tx_ready), .o_tx_valid(tx_valid), .o_tx_data(tx_data),
      .o_busy(busy), .o_done(done), .o_dbg_state(dbg_state)
   );

   wtch_time_tx #(.SEND_CRLF(1'b0)) dut_nc (
      .i_clk(clk), .i_rst(rst), .i_req(req_nc), .i_hour(hour), .i_min(min), .i_sec(sec),
      .i_msec(msec), .i_tx_ready(tx_ready), .o_tx_valid(nc_valid), .o_tx_data(nc_data),
      .o_busy(nc_busy), .o_done(nc_done), .o_dbg_state(nc_dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_time(input int h, input int m, input int s, input int c);
      hour = 5'(h);
      min  = 6'(m);
      sec  = 6'(s);
      msec = 7'(c);
   endtask

   // Drives req for one cycle at a negedge; returns at the negedge after the capture edge.
   task automatic pulse_req(input bit nc);
      if (nc) req_nc = 1'b1; else req = 1'b1;
      @(negedge clk);
      req    = 1'b0;
      req_nc = 1'b0;
   endtask

   function automatic logic [7:0] exp_byte(input string body, input int idx);
      if (idx < 11) return body[idx];
      if (idx == 11) return 8'h0D;
      return 8'h0A;
   endfunction

   // Collects one frame starting at a negedge where tx_valid is expected high.
   // Returns at the negedge following the last transfer, after checking done/busy.
   task automatic collect(input bit nc, input string body, input bit rnd, input bit chg,
                          input int req_a, input int req_b, input string name,
                          output int cycles);
      int         n;
      int         cnt;
      bit         prev_stall;
      logic [7:0] prev_data;
      logic       v;
      logic [7:0] d;
      logic       rdy;
      n          = nc ? 11 : 13;
      cnt        = 0;
      cycles     = 0;
      prev_stall = 1'b0;
      prev_data  = 8'h00;
      while (cnt < n && cycles < 300) begin
         v = nc ? nc_valid : tx_valid;
         d = nc ? nc_data : tx_data;
         checks++;
         if (v !== 1'b1) begin
            errors++;
            $display("FAIL %s valid at byte %0d: got %b, expected 1", name, cnt, v);
         end
         if (prev_stall) begin
            checks++;
            if (d !== prev_data) begin
               errors++;
               $display("FAIL %s stall hold at byte %0d: got %h, expected %h", name, cnt, d,
                        prev_data);
            end
         end
         rdy      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tx_ready = rdy;
         if (!nc) req = (cnt == req_a || cnt == req_b);
         if (chg) set_time($urandom_range(0, 31), $urandom_range(0, 63),
                           $urandom_range(0, 63), $urandom_range(0, 127));
         if (v === 1'b1 && rdy) begin
            checks++;
            if (d !== exp_byte(body, cnt)) begin
               errors++;
               $display("FAIL %s byte %0d: got %h, expected %h", name, cnt, d,
                        exp_byte(body, cnt));
            end
            cnt++;
            prev_stall = 1'b0;
         end else begin
            prev_stall = 1'b1;
            prev_data  = d;
         end
         cycles++;
         @(negedge clk);
      end
      req      = 1'b0;
      tx_ready = 1'b1;
      checks++;
      if (cnt != n) begin
         errors++;
         $display("FAIL %s timeout: got %0d bytes, expected %0d", name, cnt, n);
      end
      checks++;
      if ((nc ? nc_done : done) !== 1'b1) begin
         errors++;
         $display("FAIL %s done pulse: got %b, expected 1", name, nc ? nc_done : done);
      end
      checks++;
      if ((nc ? nc_busy : busy) !== 1'b0) begin
         errors++;
         $display("FAIL %s busy at done: got %b, expected 0", name, nc ? nc_busy : busy);
      end
   endtask

   task automatic expect_idle(input bit nc, input string name);
      checks++;
      if ((nc ? nc_valid : tx_valid) !== 1'b0 || (nc ? nc_busy : busy) !== 1'b0 ||
          (nc ? nc_done : done) !== 1'b0) begin
         errors++;
         $display("FAIL %s idle: got valid=%b busy=%b done=%b, expected 0 0 0", name,
                  nc ? nc_valid : tx_valid, nc ? nc_busy : busy, nc ? nc_done : done);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      req = 1'b0;
      req_nc = 1'b0;
      tx_ready = 1'b1;
      set_time(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0 ||
          dbg_state !== 1'b0) begin
         errors++;
         $display("FAIL reset: got valid=%b data=%h busy=%b done=%b state=%b, expected 0 00 0 0 0",
                  tx_valid, tx_data, busy, done, dbg_state);
      end
      checks++;
      if (nc_valid !== 1'b0 || nc_data !== 8'h00 || nc_busy !== 1'b0 || nc_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_nc: got valid=%b data=%h busy=%b done=%b, expected 0 00 0 0",
                  nc_valid, nc_data, nc_busy, nc_done);
      end
      rst = 1'b1;
      @(negedge clk);
      expect_idle(1'b0, "post_reset");
   endtask

   task automatic test_basic;
      int cyc;
      set_time(12, 34, 56, 78);
      pulse_req(1'b0);
      checks++;
      if (busy !== 1'b1 || dbg_state !== 1'b1) begin
         errors++;
         $display("FAIL basic busy/state: got %b/%b, expected 1/1", busy, dbg_state);
      end
      collect(1'b0, "12:34:56.78", 1'b0, 1'b0, -1, -1, "basic", cyc);
      checks++;
      if (cyc != 13) begin
         errors++;
         $display("FAIL basic cycles: got %0d, expected 13", cyc);
      end
      @(negedge clk);
      expect_idle(1'b0, "basic_after");
   endtask

   task automatic test_backpressure;
      int cyc;
      set_time(12, 34, 56, 78);
      pulse_req(1'b0);
      collect(1'b0, "12:34:56.78", 1'b1, 1'b1, -1, -1, "backpressure", cyc);
      @(negedge clk);
      expect_idle(1'b0, "backpressure_after");
   endtask

   task automatic test_zero_max;
      int cyc;
      set_time(0, 0, 0, 0);
      pulse_req(1'b0);
      collect(1'b0, "00:00:00.00", 1'b0, 1'b0, -1, -1, "zero", cyc);
      @(negedge clk);
      set_time(23, 59, 59, 99);
      pulse_req(1'b0);
      collect(1'b0, "23:59:59.99", 1'b0, 1'b0, -1, -1, "max", cyc);
      @(negedge clk);
      set_time(31, 7, 63, 127);
      pulse_req(1'b0);
      collect(1'b0, "23:07:59.99", 1'b0, 1'b0, -1, -1, "saturate", cyc);
      @(negedge clk);
      expect_idle(1'b0, "saturate_after");
   endtask

   task automatic test_back_to_back;
      int cyc;
      set_time(1, 2, 3, 4);
      pulse_req(1'b0);
      set_time(9, 8, 7, 6);
      collect(1'b0, "01:02:03.04", 1'b0, 1'b0, 4, 9, "busy_req_first", cyc);
      // Values presented now are the ones captured as the pending frame starts.
      set_time(21, 43, 5, 17);
      @(negedge clk);
      set_time(0, 0, 0, 0);
      collect(1'b0, "21:43:05.17", 1'b0, 1'b0, -1, -1, "busy_req_second", cyc);
      repeat (3) begin
         @(negedge clk);
         expect_idle(1'b0, "busy_req_no_third");
      end
   endtask

   task automatic test_reset_mid_frame;
      int cyc;
      set_time(12, 34, 56, 78);
      pulse_req(1'b0);
      tx_ready = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h35) begin
         errors++;
         $display("FAIL midreset byte6: got valid=%b data=%h, expected 1 35", tx_valid, tx_data);
      end
      rst = 1'b0;
      #1;
      expect_idle(1'b0, "midreset_async");
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      expect_idle(1'b0, "midreset_released");
      set_time(5, 6, 7, 8);
      pulse_req(1'b0);
      collect(1'b0, "05:06:07.08", 1'b0, 1'b0, -1, -1, "midreset_next", cyc);
      @(negedge clk);
   endtask

   task automatic test_no_crlf;
      int cyc;
      set_time(12, 34, 56, 78);
      pulse_req(1'b1);
      collect(1'b1, "12:34:56.78", 1'b0, 1'b0, -1, -1, "no_crlf", cyc);
      checks++;
      if (cyc != 11) begin
         errors++;
         $display("FAIL no_crlf cycles: got %0d, expected 11", cyc);
      end
      @(negedge clk);
      expect_idle(1'b1, "no_crlf_after");
   endtask

   initial begin
      test_reset;
      test_basic;
      test_backpressure;
      test_zero_max;
      test_back_to_back;
      test_reset_mid_frame;
      test_no_crlf;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
